acq_sequencer: RTL and testbench

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

---
 rtl/acq_sequencer.sv | 160 ++++++++++++++++
 tb/tb_acq_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: runs a detector through restart/settle/count windows
// and hands each window's counters to a consumer through a valid/ready snapshot.
module acq_sequencer #(
   parameter int NCHAN   = 4,
   parameter int NBITS   = 4,
   parameter int NSETTLE = 4
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic                      Start_i,
   input  logic                      Stop_i,
   input  logic [7:0]                NumWin_i,
   input  logic [NBITS-1:0]          nCycles_i,
   input  logic [NCHAN*NBITS-1:0]    Delays_i,
   output logic                      Det_Restart_o,
   output logic                      Det_Enable_o,
   output logic [NBITS-1:0]          Det_nCycles_o,
   output logic [NCHAN*NBITS-1:0]    Det_Delays_o,
   input  logic [NBITS-1:0]          Det_CntClk_i,
   input  logic [NCHAN*NBITS-1:0]    Det_CntChann_i,
   input  logic [NCHAN*(NCHAN-1)/2*NBITS-1:0] Det_CntPairs_i,
   output logic                      Res_Valid_o,
   input  logic                      Res_Ready_i,
   output logic [NCHAN*NBITS-1:0]    Res_CntChann_o,
   output logic [NCHAN*(NCHAN-1)/2*NBITS-1:0] Res_CntPairs_o,
   output logic [7:0]                Res_WinIdx_o,
   output logic                      Busy_o,
   output logic                      Done_o,
   output logic                      Overrun_o
);

   localparam int NPAIRS = NCHAN*(NCHAN-1)/2;
   localparam int SW     = $clog2(NSETTLE+1);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SETTLE, S_RUN, S_CAPTURE} state_t;

   state_t                    state_q, state_d;
   logic [NBITS-1:0]          ncyc_q, ncyc_d;
   logic [NCHAN*NBITS-1:0]    dly_q, dly_d;
   logic [7:0]                target_q, target_d;
   logic [7:0]                win_q, win_d;
   logic                      stop_q, stop_d;
   logic [SW-1:0]             settle_q, settle_d;
   logic                      valid_q, valid_d;
   logic [NCHAN*NBITS-1:0]    chann_q, chann_d;
   logic [NPAIRS*NBITS-1:0]   pairs_q, pairs_d;
   logic [7:0]                idx_q, idx_d;
   logic                      done_q, done_d;
   logic                      ovr_q, ovr_d;

   // NOTE: every signal gets its hold value first so no path through the case infers a latch.
   always_comb begin
      state_d  = state_q;
      ncyc_d   = ncyc_q;
      dly_d    = dly_q;
      target_d = target_q;
      win_d    = win_q;
      stop_d   = stop_q;
      settle_d = settle_q;
      valid_d  = valid_q;
      chann_d  = chann_q;
      pairs_d  = pairs_q;
      idx_d    = idx_q;
      done_d   = 1'b0;
      ovr_d    = ovr_q;

      if (valid_q && Res_Ready_i) valid_d = 1'b0;
      if (state_q != S_IDLE && Stop_i) stop_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (Start_i) begin
               ncyc_d   = nCycles_i;
               dly_d    = Delays_i;
               target_d = NumWin_i;
               win_d    = '0;
               stop_d   = 1'b0;
               ovr_d    = 1'b0;
               state_d  = S_CLEAR;
            end
         end
         S_CLEAR: begin
            settle_d = '0;
            state_d  = S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_q == SW'(NSETTLE-1)) state_d = S_RUN;
            else settle_d = settle_q + 1'b1;
         end
         S_RUN: begin
            if (Det_CntClk_i == ncyc_q) state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            // A held result is never overwritten; the new window is dropped instead.
            if (!valid_q || Res_Ready_i) begin
               chann_d = Det_CntChann_i;
               pairs_d = Det_CntPairs_i;
               idx_d   = win_q;
               valid_d = 1'b1;
            end else begin
               ovr_d = 1'b1;
            end
            win_d = win_q + 8'd1;
            if (stop_q || Stop_i || (target_q != 8'd0 && win_d == target_q)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = S_CLEAR;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q  <= S_IDLE;
         ncyc_q   <= '0;
         dly_q    <= '0;
         target_q <= '0;
         win_q    <= '0;
         stop_q   <= 1'b0;
         settle_q <= '0;
         valid_q  <= 1'b0;
         chann_q  <= '0;
         pairs_q  <= '0;
         idx_q    <= '0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ncyc_q   <= ncyc_d;
         dly_q    <= dly_d;
         target_q <= target_d;
         win_q    <= win_d;
         stop_q   <= stop_d;
         settle_q <= settle_d;
         valid_q  <= valid_d;
         chann_q  <= chann_d;
         pairs_q  <= pairs_d;
         idx_q    <= idx_d;
         done_q   <= done_d;
         ovr_q    <= ovr_d;
      end
   end

   assign Det_Restart_o  = (state_q == S_CLEAR);
   assign Det_Enable_o   = (state_q == S_RUN);
   assign Det_nCycles_o  = ncyc_q;
   assign Det_Delays_o   = dly_q;
   assign Res_Valid_o    = valid_q;
   assign Res_CntChann_o = chann_q;
   assign Res_CntPairs_o = pairs_q;
   assign Res_WinIdx_o   = idx_q;
   assign Busy_o         = (state_q != S_IDLE);
   assign Done_o         = done_q;
   assign Overrun_o      = ovr_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer with a zero-latency behavioural detector.
module tb_acq_sequencer;

   localparam int NCHAN   = 4;
   localparam int NBITS   = 4;
   localparam int NSETTLE = 4;
   localparam int NPAIRS  = NCHAN*(NCHAN-1)/2;

   logic                    clk = 1'b0;
   logic                    Rst, Start_i, Stop_i, Res_Ready_i;
   logic [7:0]              NumWin_i;
   logic [NBITS-1:0]        nCycles_i;
   logic [NCHAN*NBITS-1:0]  Delays_i;
   logic                    Det_Restart_o, Det_Enable_o;
   logic [NBITS-1:0]        Det_nCycles_o;
   logic [NCHAN*NBITS-1:0]  Det_Delays_o;
   logic [NBITS-1:0]        det_clk;
   logic [NCHAN*NBITS-1:0]  det_chann;
   logic [NPAIRS*NBITS-1:0] det_pairs;
   logic                    Res_Valid_o;
   logic [NCHAN*NBITS-1:0]  Res_CntChann_o;
   logic [NPAIRS*NBITS-1:0] Res_CntPairs_o;
   logic [7:0]              Res_WinIdx_o;
   logic                    Busy_o, Done_o, Overrun_o;
   logic [NCHAN-1:0]        pulse_mask;

   int n_checks = 0;
   int n_fail   = 0;
   int n_acc, en_cnt, done_cnt, cyc, done_cyc, last_acc_cyc;
   logic [7:0]              idx_log   [8];
   logic [NCHAN*NBITS-1:0]  chann_log [8];
   logic [NPAIRS*NBITS-1:0] pairs_log [8];

   always #5 clk = ~clk;

   acq_sequencer #(.NCHAN(NCHAN), .NBITS(NBITS), .NSETTLE(NSETTLE)) dut (
      .Clk(clk), .Rst(Rst), .Start_i(Start_i), .Stop_i(Stop_i),
      .NumWin_i(NumWin_i), .nCycles_i(nCycles_i), .Delays_i(Delays_i),
      .Det_Restart_o(Det_Restart_o), .Det_Enable_o(Det_Enable_o),
      .Det_nCycles_o(Det_nCycles_o), .Det_Delays_o(Det_Delays_o),
      .Det_CntClk_i(det_clk), .Det_CntChann_i(det_chann), .Det_CntPairs_i(det_pairs),
      .Res_Valid_o(Res_Valid_o), .Res_Ready_i(Res_Ready_i),
      .Res_CntChann_o(Res_CntChann_o), .Res_CntPairs_o(Res_CntPairs_o),
      .Res_WinIdx_o(Res_WinIdx_o), .Busy_o(Busy_o), .Done_o(Done_o), .Overrun_o(Overrun_o)
   );

   // Detector model: masked channels pulse on odd clock counts; pairs count coincidences.
   always @(posedge clk) begin
      if (Rst || Det_Restart_o) begin
         det_clk   <= '0;
         det_chann <= '0;
         det_pairs <= '0;
      end else if (Det_Enable_o) begin
         det_clk <= det_clk + 1'b1;
         if (det_clk[0]) begin
            for (int i = 0; i < NCHAN; i++) begin
               if (pulse_mask[i]) det_chann[i*NBITS +: NBITS] <= det_chann[i*NBITS +: NBITS] + 1'b1;
               for (int j = i+1; j < NCHAN; j++)
                  if (pulse_mask[i] && pulse_mask[j])
                     det_pairs[(i*NCHAN - i*(i+1)/2 + j-i-1)*NBITS +: NBITS] <=
                        det_pairs[(i*NCHAN - i*(i+1)/2 + j-i-1)*NBITS +: NBITS] + 1'b1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Tallies describe the cycle that ends at the upcoming edge.
   task automatic tick();
      logic hs;
      hs = (Res_Valid_o === 1'b1) && (Res_Ready_i === 1'b1);
      if (hs && n_acc < 8) begin
         idx_log[n_acc]   = Res_WinIdx_o;
         chann_log[n_acc] = Res_CntChann_o;
         pairs_log[n_acc] = Res_CntPairs_o;
      end
      if (hs) begin
         n_acc++;
         last_acc_cyc = cyc;
      end
      if (Det_Enable_o === 1'b1) en_cnt++;
      if (Done_o === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_tally();
      n_acc = 0; en_cnt = 0; done_cnt = 0; done_cyc = -1; last_acc_cyc = -2;
   endtask

   task automatic start_run(input logic [7:0] nwin, input logic [NBITS-1:0] ncyc,
                            input logic [NCHAN*NBITS-1:0] dly);
      NumWin_i = nwin; nCycles_i = ncyc; Delays_i = dly;
      clear_tally();
      Start_i = 1'b1;
      tick();
      Start_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget && Busy_o === 1'b1; i++) tick();
      check(tag, 32'(Busy_o), 32'd0);
      tick();
   endtask

   initial begin
      Rst = 1'b1; Start_i = 1'b0; Stop_i = 1'b0; Res_Ready_i = 1'b1;
      NumWin_i = '0; nCycles_i = '0; Delays_i = '0; pulse_mask = '0; cyc = 0;
      clear_tally();
      tick(); tick();
      check("rst_busy", 32'(Busy_o), 32'd0);
      check("rst_restart", 32'(Det_Restart_o), 32'd0);
      check("rst_enable", 32'(Det_Enable_o), 32'd0);
      check("rst_valid", 32'(Res_Valid_o), 32'd0);
      check("rst_ncyc", 32'(Det_nCycles_o), 32'd0);
      check("rst_overrun", 32'(Overrun_o), 32'd0);
      Rst = 1'b0;
      tick();
      check("rst_restart_after", 32'(Det_Restart_o), 32'd0);

      // Two windows of 5 cycles, ch0/ch1 coincident three times per window.
      pulse_mask = 4'b0011;
      start_run(8'd2, 4'd5, 16'h4321);
      check("t1_restart", 32'(Det_Restart_o), 32'd1);
      check("t1_ncyc", 32'(Det_nCycles_o), 32'd5);
      check("t1_delays", 32'(Det_Delays_o), 32'h4321);
      for (int i = 0; i < NSETTLE; i++) tick();
      check("t1_settle_en", 32'(Det_Enable_o), 32'd0);
      tick();
      check("t1_run_en", 32'(Det_Enable_o), 32'd1);
      nCycles_i = 4'd9; Start_i = 1'b1;
      tick();
      Start_i = 1'b0; nCycles_i = 4'd5;
      check("t1_start_ignored", 32'(Det_nCycles_o), 32'd5);
      wait_idle("t1_idle_timeout", 60);
      check("t1_results", 32'(n_acc), 32'd2);
      check("t1_idx0", 32'(idx_log[0]), 32'd0);
      check("t1_idx1", 32'(idx_log[1]), 32'd1);
      check("t1_chann", 32'(chann_log[0]), 32'h0033);
      check("t1_pairs", 32'(pairs_log[0]), 32'h000003);
      check("t1_chann_w1", 32'(chann_log[1]), 32'h0033);
      check("t1_enable_cycles", 32'(en_cnt), 32'd12);
      check("t1_done_cnt", 32'(done_cnt), 32'd1);
      check("t1_done_timing", 32'(done_cyc), 32'(last_acc_cyc));
      check("t1_overrun", 32'(Overrun_o), 32'd0);

      // Continuous, consumer stalled: window 0 held, later windows dropped.
      pulse_mask = 4'b0000; Res_Ready_i = 1'b0;
      start_run(8'd0, 4'd2, 16'h0000);
      for (int i = 0; i < 22; i++) tick();
      check("t2_valid", 32'(Res_Valid_o), 32'd1);
      check("t2_idx", 32'(Res_WinIdx_o), 32'd0);
      check("t2_overrun", 32'(Overrun_o), 32'd1);
      check("t2_busy", 32'(Busy_o), 32'd1);
      Stop_i = 1'b1; tick(); Stop_i = 1'b0;
      wait_idle("t2_idle_timeout", 40);
      check("t2_done_cnt", 32'(done_cnt), 32'd1);
      check("t2_idx_held", 32'(Res_WinIdx_o), 32'd0);
      check("t2_overrun_sticky", 32'(Overrun_o), 32'd1);
      Res_Ready_i = 1'b1;
      tick();
      check("t2_valid_cleared", 32'(Res_Valid_o), 32'd0);

      // Continuous run stopped during window 3.
      start_run(8'd0, 4'd3, 16'h0000);
      check("t3_overrun_clr", 32'(Overrun_o), 32'd0);
      for (int i = 0; i < 60 && n_acc < 3; i++) tick();
      check("t3_three_windows", 32'(n_acc), 32'd3);
      for (int i = 0; i < 20 && Det_Enable_o !== 1'b1; i++) tick();
      check("t3_run_reached", 32'(Det_Enable_o), 32'd1);
      tick();
      Stop_i = 1'b1; tick(); Stop_i = 1'b0;
      wait_idle("t3_idle_timeout", 30);
      check("t3_results", 32'(n_acc), 32'd4);
      check("t3_idx3", 32'(idx_log[3]), 32'd3);
      check("t3_done_cnt", 32'(done_cnt), 32'd1);

      // Reset in the middle of window 2 with window 1's result pending.
      start_run(8'd0, 4'd5, 16'h1234);
      for (int i = 0; i < 40 && n_acc < 1; i++) tick();
      Res_Ready_i = 1'b0;
      for (int i = 0; i < 60 && !(Res_Valid_o === 1'b1 && Det_Enable_o === 1'b1); i++) tick();
      check("t4_pending_idx", 32'(Res_WinIdx_o), 32'd1);
      tick(); tick();
      Rst = 1'b1; tick(); Rst = 1'b0;
      check("t4_busy", 32'(Busy_o), 32'd0);
      check("t4_enable", 32'(Det_Enable_o), 32'd0);
      check("t4_restart", 32'(Det_Restart_o), 32'd0);
      check("t4_ncyc", 32'(Det_nCycles_o), 32'd0);
      check("t4_delays", 32'(Det_Delays_o), 32'd0);
      check("t4_valid", 32'(Res_Valid_o), 32'd0);
      check("t4_idx", 32'(Res_WinIdx_o), 32'd0);
      check("t4_chann", 32'(Res_CntChann_o), 32'd0);
      check("t4_done", 32'(Done_o), 32'd0);
      check("t4_overrun", 32'(Overrun_o), 32'd0);
      Res_Ready_i = 1'b1; pulse_mask = 4'b1111;
      start_run(8'd1, 4'd2, 16'h0000);
      wait_idle("t4_idle_timeout", 30);
      check("t4_results", 32'(n_acc), 32'd1);
      check("t4_idx0", 32'(idx_log[0]), 32'd0);
      check("t4_chann_all", 32'(chann_log[0]), 32'h1111);
      check("t4_pairs_all", 32'(pairs_log[0]), 32'h111111);
      check("t4_done_cnt", 32'(done_cnt), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
